hazard_fwd_unit: RTL and testbench

Parametrised successor to the current forwarding unit in the 5-stage RISC-V pipeline.
- Produces forwarding selects and the forwarded ALU operands for both EX operands.
- Detects load-use hazards and inserts a one-cycle bubble.
- Freezes the pipeline for multi-cycle data-memory accesses.
- Sequences flushes of younger stages when a branch resolves taken in MEM.
- Sits between the pipeline registers and the EX-stage operand muxes, driving hold, bubble and flush controls.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/fwd_sel_mux.sv | 43 ++++
 rtl/hazard_fwd_unit.sv | 187 ++++++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the hazard/forwarding unit.
//   - FSM state encoding
//   - forward-select codes (mux input order: 0=reg, 1=WB, 2=MEM)
//   - flush_vec bit positions
//   - saturating 16-bit increment used by the perf counters
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } hz_state_t;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    localparam int FL_IF_ID  = 0;
    localparam int FL_ID_EX  = 1;
    localparam int FL_EX_MEM = 2;

    // Width of the memory-wait down-counter (MEM_LAT <= 8 -> load value <= 6).
    localparam int WAIT_W = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fwd_sel_mux.sv
// fwd_sel_mux: per-operand forwarding select and operand mux.
//   en           : when low, select is forced to the register operand
//   rs, rs_data  : EX source index and its register-file/immediate value
//   mem_*        : EX/MEM destination, controls and ALU result
//   wb_*         : MEM/WB destination, write enable and write-back data
//   sel, fwd     : chosen source code and the forwarded operand
// A load sitting in MEM has no data yet, so it is never a MEM source;
// the load-use stall lets it arrive through WB instead. x0 never forwards.
module fwd_sel_mux
    import hazard_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              en,
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regw,
    input  logic              mem_memr,
    input  logic [XLEN-1:0]   mem_alu_rslt,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regw,
    input  logic [XLEN-1:0]   wb_data,
    output logic [1:0]        sel,
    output logic [XLEN-1:0]   fwd
);

    always_comb begin
        sel = FWD_REG;
        fwd = rs_data;
        if (en) begin
            if (mem_regw && (mem_rd != '0) && (mem_rd == rs) && !mem_memr) begin
                sel = FWD_MEM;
                fwd = mem_alu_rslt;
            end else if (wb_regw && (wb_rd != '0) && (wb_rd == rs)) begin
                sel = FWD_WB;
                fwd = wb_data;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EX operand forwarding plus pipeline hazard control.
//   clk, start       : clock and synchronous active-low reset
//   id_*             : ID-stage source indices and use flags (load-use check)
//   ex_*             : ID/EX sources, operands, destination and controls
//   mem_*            : EX/MEM destination, controls and ALU result
//   wb_*             : MEM/WB destination, write enable and write-back data
//   br_taken         : branch resolved taken in MEM
//   sel_a/b, fwd_a/b : forwarding selects and forwarded ALU operands
//   pc_hold, if_id_hold, id_ex_bubble, ex_mem_hold, mem_wb_hold : stall controls
//   flush_vec        : bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM
//   stall_cnt, flush_cnt : saturating perf counters
// Build option: HAZARD_PERF_CNT_EN builds the perf counters; otherwise both
// counter outputs are tied to zero and no counter flops exist.
// Hold/bubble outputs are decoded from state and current inputs so that a
// hazard stalls the very cycle it is detected; flush_vec is decoded from
// state alone (one cycle after br_taken).
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int MEM_LAT      = 1,
    parameter int FLUSH_STAGES = 3
) (
    input  logic              clk,
    input  logic              start,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [XLEN-1:0]   ex_rs1_data,
    input  logic [XLEN-1:0]   ex_rs2_data,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regw,
    input  logic              ex_memr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regw,
    input  logic              mem_memr,
    input  logic              mem_memw,
    input  logic [XLEN-1:0]   mem_alu_rslt,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regw,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              br_taken,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b,
    output logic [XLEN-1:0]   fwd_a,
    output logic [XLEN-1:0]   fwd_b,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              id_ex_bubble,
    output logic              ex_mem_hold,
    output logic              mem_wb_hold,
    output logic [2:0]        flush_vec,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    localparam int NUM_OPS = 2;
    localparam logic [2:0] FLUSH_MASK = 3'((1 << FLUSH_STAGES) - 1);
    // The detecting RUN cycle is the first hold cycle, so the counter covers
    // the remaining MEM_LAT-2 before the releasing cycle.
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    // ---------------- forwarding ----------------
    logic [NUM_OPS-1:0][REG_AW-1:0] op_rs;
    logic [NUM_OPS-1:0][XLEN-1:0]   op_data;
    logic [NUM_OPS-1:0][XLEN-1:0]   op_fwd;
    logic [NUM_OPS-1:0][1:0]        op_sel;

    assign op_rs   = {ex_rs2, ex_rs1};
    assign op_data = {ex_rs2_data, ex_rs1_data};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        fwd_sel_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_mux (
            .en           (start),
            .rs           (op_rs[i]),
            .rs_data      (op_data[i]),
            .mem_rd       (mem_rd),
            .mem_regw     (mem_regw),
            .mem_memr     (mem_memr),
            .mem_alu_rslt (mem_alu_rslt),
            .wb_rd        (wb_rd),
            .wb_regw      (wb_regw),
            .wb_data      (wb_data),
            .sel          (op_sel[i]),
            .fwd          (op_fwd[i])
        );
    end

    assign sel_a = op_sel[0];
    assign sel_b = op_sel[1];
    assign fwd_a = op_fwd[0];
    assign fwd_b = op_fwd[1];

    // ---------------- hazard detection ----------------
    hz_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lu_hit, mem_acc;
    logic              hold_all, lu_stall;

    assign lu_hit = ex_memr && ex_regw && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));
    assign mem_acc = (mem_memr || mem_memw) && (MEM_LAT > 1);

    always_comb begin
        hold_all  = 1'b0;
        lu_stall  = 1'b0;
        flush_vec = 3'b000;
        if (start) begin
            unique case (state)
                RUN: begin
                    // br_taken wins: the ID instruction is flushed anyway.
                    if (!br_taken) begin
                        if (mem_acc)     hold_all = 1'b1;
                        else if (lu_hit) lu_stall = 1'b1;
                    end
                end
                MEM_WAIT: hold_all  = (wait_cnt != '0);
                FLUSH:    flush_vec = FLUSH_MASK;
                default:  ;
            endcase
        end
    end

    assign pc_hold      = hold_all | lu_stall;
    assign if_id_hold   = hold_all | lu_stall;
    assign id_ex_bubble = lu_stall;
    assign ex_mem_hold  = hold_all;
    assign mem_wb_hold  = hold_all;

    always_ff @(posedge clk) begin
        if (!start) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (br_taken) begin
                        state <= FLUSH;
                    end else if (mem_acc) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end else if (lu_hit) begin
                        state <= LU_STALL;
                    end
                end
                LU_STALL: state <= RUN;
                MEM_WAIT: begin
                    // The access that caused the wait is not re-examined here.
                    if (wait_cnt == '0) state <= RUN;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
                FLUSH:    state <= RUN;
                default:  state <= RUN;
            endcase
        end
    end

    // ---------------- perf counters ----------------
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_q, flush_q;
    logic        flush_entry;

    assign flush_entry = start && (state == RUN) && br_taken;

    always_ff @(posedge clk) begin
        if (!start) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_hold)     stall_q <= sat_inc16(stall_q);
            if (flush_entry) flush_q <= sat_inc16(flush_q);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: two instances share the stimulus,
// u_dut (MEM_LAT=3, FLUSH_STAGES=3) and u_dut2 (MEM_LAT=1, FLUSH_STAGES=2).
module tb_hazard_fwd_unit;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        start;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_rs1_used, id_rs2_used, ex_regw, ex_memr;
    logic        mem_regw, mem_memr, mem_memw, wb_regw, br_taken;
    logic [31:0] ex_rs1_data, ex_rs2_data, mem_alu_rslt, wb_data;

    logic [1:0]  sel_a, sel_b, sel_a2, sel_b2;
    logic [31:0] fwd_a, fwd_b, fwd_a2, fwd_b2;
    logic        pc_hold, if_id_hold, id_ex_bubble, ex_mem_hold, mem_wb_hold;
    logic        pc_hold2, if_id_hold2, id_ex_bubble2, ex_mem_hold2, mem_wb_hold2;
    logic [2:0]  flush_vec, flush_vec2;
    logic [15:0] stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.XLEN(32), .REG_AW(5), .MEM_LAT(3), .FLUSH_STAGES(3)) u_dut (
        .clk(clk), .start(start),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rd(ex_rd), .ex_regw(ex_regw), .ex_memr(ex_memr),
        .mem_rd(mem_rd), .mem_regw(mem_regw), .mem_memr(mem_memr), .mem_memw(mem_memw),
        .mem_alu_rslt(mem_alu_rslt), .wb_rd(wb_rd), .wb_regw(wb_regw), .wb_data(wb_data),
        .br_taken(br_taken), .sel_a(sel_a), .sel_b(sel_b), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_bubble(id_ex_bubble),
        .ex_mem_hold(ex_mem_hold), .mem_wb_hold(mem_wb_hold), .flush_vec(flush_vec),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_fwd_unit #(.XLEN(32), .REG_AW(5), .MEM_LAT(1), .FLUSH_STAGES(2)) u_dut2 (
        .clk(clk), .start(start),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rd(ex_rd), .ex_regw(ex_regw), .ex_memr(ex_memr),
        .mem_rd(mem_rd), .mem_regw(mem_regw), .mem_memr(mem_memr), .mem_memw(mem_memw),
        .mem_alu_rslt(mem_alu_rslt), .wb_rd(wb_rd), .wb_regw(wb_regw), .wb_data(wb_data),
        .br_taken(br_taken), .sel_a(sel_a2), .sel_b(sel_b2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
        .pc_hold(pc_hold2), .if_id_hold(if_id_hold2), .id_ex_bubble(id_ex_bubble2),
        .ex_mem_hold(ex_mem_hold2), .mem_wb_hold(mem_wb_hold2), .flush_vec(flush_vec2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clr();
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rs1_data = 32'h0000_00AA; ex_rs2_data = 32'h0000_00BB;
        ex_rd = '0; ex_regw = 0; ex_memr = 0;
        mem_rd = '0; mem_regw = 0; mem_memr = 0; mem_memw = 0; mem_alu_rslt = '0;
        wb_rd = '0; wb_regw = 0; wb_data = '0; br_taken = 0;
    endtask

    // Advance one clock; inputs are changed and outputs sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_load_use();
        ex_memr = 1; ex_regw = 1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_rs2 = 5'd5; id_rs1_used = 1; id_rs2_used = 1;
    endtask

    initial begin
        clr();
        // Reset cycle with hazards on the inputs: everything must stay quiet.
        start = 0;
        set_load_use();
        mem_rd = 5'd1; mem_regw = 1; ex_rs1 = 5'd1; br_taken = 1;
        settle();
        chk("rst_pc_hold", {31'd0, pc_hold}, 0);
        chk("rst_bubble", {31'd0, id_ex_bubble}, 0);
        chk("rst_sel_a", {30'd0, sel_a}, 0);
        chk("rst_flush_vec", {29'd0, flush_vec}, 0);
        tick();
        tick();
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 0);
        chk("rst_flush_cnt", {16'd0, flush_cnt}, 0);

        // RAW from MEM: add x5 in MEM, sub reads x5 in EX.
        start = 1; clr();
        ex_rs1 = 5'd5; ex_rs2 = 5'd3; ex_rs1_data = 32'h99; ex_rs2_data = 32'h33;
        mem_rd = 5'd5; mem_regw = 1; mem_alu_rslt = 32'h0000_0011;
        settle();
        chk("raw_sel_a", {30'd0, sel_a}, 2);
        chk("raw_fwd_a", fwd_a, 32'h0000_0011);
        chk("raw_sel_b", {30'd0, sel_b}, 0);
        chk("raw_fwd_b", fwd_b, 32'h33);
        chk("raw_no_hold", {31'd0, pc_hold}, 0);

        // MEM beats WB; a load in MEM falls back to WB.
        clr();
        ex_rs1 = 5'd7; mem_rd = 5'd7; mem_regw = 1; mem_alu_rslt = 32'h1111;
        wb_rd = 5'd7; wb_regw = 1; wb_data = 32'h2222;
        settle();
        chk("prio_sel_a", {30'd0, sel_a}, 2);
        chk("prio_fwd_a", fwd_a, 32'h1111);
        mem_memr = 1;
        settle();
        chk("ldmem_sel_a", {30'd0, sel_a}, 1);
        chk("ldmem_fwd_a", fwd_a, 32'h2222);
        clr();
        settle();

        // Load-use: lw x5 in EX, add x6,x5,x5 in ID.
        set_load_use();
        settle();
        chk("lu_pc_hold", {31'd0, pc_hold}, 1);
        chk("lu_if_id_hold", {31'd0, if_id_hold}, 1);
        chk("lu_bubble", {31'd0, id_ex_bubble}, 1);
        chk("lu_no_exmem_hold", {31'd0, ex_mem_hold}, 0);
        tick();
        clr();
        settle();
        chk("lu_one_cycle", {30'd0, pc_hold, id_ex_bubble}, 0);
        tick();
        ex_rs1 = 5'd5; ex_rs2 = 5'd5; wb_rd = 5'd5; wb_regw = 1; wb_data = 32'hDEAD_BEEF;
        settle();
        chk("lu_sel_a", {30'd0, sel_a}, 1);
        chk("lu_sel_b", {30'd0, sel_b}, 1);
        chk("lu_fwd_a", fwd_a, 32'hDEAD_BEEF);
        chk("lu_fwd_b", fwd_b, 32'hDEAD_BEEF);
        chk("lu_stall_cnt", {16'd0, stall_cnt}, PERF ? 1 : 0);
        chk("lu_stall_cnt2", {16'd0, stall_cnt2}, PERF ? 1 : 0);

        // sw in MEM with MEM_LAT=3: two hold cycles, then release, no repeat.
        clr();
        mem_memw = 1;
        settle();
        chk("mw1_holds", {27'd0, pc_hold, if_id_hold, ex_mem_hold, mem_wb_hold, id_ex_bubble}, 5'b11110);
        chk("mw1_lat1_no_hold", {31'd0, pc_hold2}, 0);
        tick();
        chk("mw2_holds", {27'd0, pc_hold, if_id_hold, ex_mem_hold, mem_wb_hold, id_ex_bubble}, 5'b11110);
        tick();
        chk("mw3_release", {28'd0, pc_hold, if_id_hold, ex_mem_hold, mem_wb_hold}, 0);
        tick();
        mem_memw = 0;
        settle();
        chk("mw4_no_repeat", {28'd0, pc_hold, if_id_hold, ex_mem_hold, mem_wb_hold}, 0);
        chk("mw_stall_cnt", {16'd0, stall_cnt}, PERF ? 3 : 0);

        // Taken branch: flush one cycle later, for one cycle.
        br_taken = 1;
        settle();
        chk("br_no_flush_yet", {29'd0, flush_vec}, 0);
        tick();
        clr();
        settle();
        chk("br_flush3", {29'd0, flush_vec}, 3'b111);
        chk("br_flush2", {29'd0, flush_vec2}, 3'b011);
        tick();
        chk("br_flush_done", {29'd0, flush_vec}, 0);
        chk("br_flush_cnt", {16'd0, flush_cnt}, PERF ? 1 : 0);

        // Branch and load-use together: flush only.
        set_load_use();
        br_taken = 1;
        settle();
        chk("brlu_bubble", {31'd0, id_ex_bubble}, 0);
        chk("brlu_pc_hold", {31'd0, pc_hold}, 0);
        tick();
        clr();
        settle();
        chk("brlu_flush", {29'd0, flush_vec}, 3'b111);
        tick();
        chk("brlu_stall_cnt", {16'd0, stall_cnt}, PERF ? 3 : 0);
        chk("brlu_flush_cnt", {16'd0, flush_cnt}, PERF ? 2 : 0);

        // x0 writers never forward.
        mem_rd = 5'd0; mem_regw = 1; mem_alu_rslt = 32'h5555;
        wb_rd = 5'd0; wb_regw = 1; wb_data = 32'h6666;
        ex_rs1 = 5'd0; ex_rs1_data = 32'h1234;
        settle();
        chk("x0_sel_a", {30'd0, sel_a}, 0);
        chk("x0_fwd_a", fwd_a, 32'h1234);

        // Reset in the middle of a memory wait.
        clr();
        mem_memw = 1;
        tick();
        chk("rw_holding", {31'd0, ex_mem_hold}, 1);
        start = 0;
        mem_memw = 0;
        settle();
        chk("rw_rst_cycle", {28'd0, pc_hold, if_id_hold, ex_mem_hold, mem_wb_hold}, 0);
        tick();
        start = 1;
        settle();
        chk("rw_after_holds", {28'd0, pc_hold, if_id_hold, ex_mem_hold, mem_wb_hold}, 0);
        chk("rw_stall_cnt", {16'd0, stall_cnt}, 0);
        chk("rw_flush_cnt", {16'd0, flush_cnt}, 0);
        tick();
        chk("rw_still_idle", {31'd0, pc_hold}, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
